// File: rtl/lfsr_cfg_regs_pkg.sv
// rtl/lfsr_cfg_regs_pkg.sv - shared constants and LFSR feedback table for lfsr_cfg_regs
package lfsr_cfg_regs_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int DEG_W  = 5;
    localparam int MASK_W = 16;
    localparam int LEN_W  = 17;

    localparam int MODE_W = 4;
    localparam int AMPL_W = 14;

    localparam logic [ADDR_W-1:0] ADDR_MODE_DEF   = 7'd64;
    localparam logic [ADDR_W-1:0] ADDR_DEGREE_DEF = 7'd65;
    localparam logic [ADDR_W-1:0] ADDR_AMPL_DEF   = 7'd66;

    localparam int MAX_DEGREE = 16;

    // Maximal-length feedback taps indexed by degree; degree 0 is a degenerate all-zero entry.
    localparam logic [MASK_W-1:0] MASK_TABLE [0:MAX_DEGREE] = '{
        16'h0000, 16'h0001, 16'h0003, 16'h0005,
        16'h0009, 16'h0012, 16'h0021, 16'h0041,
        16'h008E, 16'h0108, 16'h0204, 16'h0402,
        16'h0829, 16'h100D, 16'h2015, 16'h4001,
        16'h8016
    };

    function automatic logic degree_supported(input logic [DEG_W-1:0] degree);
        return degree <= DEG_W'(MAX_DEGREE);
    endfunction

endpackage

// File: rtl/lfsr_constants.sv
// rtl/lfsr_constants.sv - registered degree-to-feedback-mask and sequence-length lookup
import lfsr_cfg_regs_pkg::*;

module lfsr_constants (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DEG_W-1:0] degree_i,
    output logic [MASK_W-1:0] mask_o,
    output logic [LEN_W-1:0]  len_o
);

    logic [MASK_W-1:0] w_mask;
    logic [LEN_W-1:0]  w_len;
    logic [MASK_W-1:0] r_mask;
    logic [LEN_W-1:0]  r_len;

    // Unsupported degrees yield zeros so downstream sequencers stay idle.
    always_comb begin
        w_mask = '0;
        w_len  = '0;
        if (degree_supported(degree_i)) begin
            w_mask = MASK_TABLE[degree_i];
            w_len  = (LEN_W'(1) << degree_i) - LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mask <= '0;
            r_len  <= '0;
        end else begin
            r_mask <= w_mask;
            r_len  <= w_len;
        end
    end

    assign mask_o = r_mask;
    assign len_o  = r_len;

endmodule

// File: rtl/setting_reg.sv
// rtl/setting_reg.sv - address-decoded setting register loaded from the configuration bus
import lfsr_cfg_regs_pkg::*;

module setting_reg #(
    parameter logic [ADDR_W-1:0] ADDR  = '0,
    parameter int                WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              strobe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] in,
    output logic [WIDTH-1:0]  out
);

    logic             w_hit;
    logic [WIDTH-1:0] r_value;

    assign w_hit = strobe && (addr == ADDR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_value <= '0;
        end else if (w_hit) begin
            r_value <= in[WIDTH-1:0];
        end
    end

    assign out = r_value;

endmodule

// File: rtl/lfsr_cfg_regs.sv
// rtl/lfsr_cfg_regs.sv - configuration front end: setting registers plus LFSR constants
import lfsr_cfg_regs_pkg::*;

module lfsr_cfg_regs #(
    parameter logic [ADDR_W-1:0] ADDR_MODE   = ADDR_MODE_DEF,
    parameter logic [ADDR_W-1:0] ADDR_DEGREE = ADDR_DEGREE_DEF,
    parameter logic [ADDR_W-1:0] ADDR_AMPL   = ADDR_AMPL_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] saddr_i,
    input  logic [DATA_W-1:0] sdata_i,
    input  logic              s_strobe_i,
    output logic              reset_o,
    output logic              transmit_o,
    output logic              receive_o,
    output logic              loopback_o,
    output logic [DEG_W-1:0]  degree_o,
    output logic [AMPL_W-1:0] ampl_o,
    output logic [MASK_W-1:0] mask_o,
    output logic [LEN_W-1:0]  len_o
);

    logic [MODE_W-1:0] w_mode;

    setting_reg #(.ADDR(ADDR_MODE), .WIDTH(MODE_W)) u_mode_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .strobe (s_strobe_i),
        .addr   (saddr_i),
        .in     (sdata_i),
        .out    (w_mode)
    );

    setting_reg #(.ADDR(ADDR_DEGREE), .WIDTH(DEG_W)) u_degree_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .strobe (s_strobe_i),
        .addr   (saddr_i),
        .in     (sdata_i),
        .out    (degree_o)
    );

    setting_reg #(.ADDR(ADDR_AMPL), .WIDTH(AMPL_W)) u_ampl_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .strobe (s_strobe_i),
        .addr   (saddr_i),
        .in     (sdata_i),
        .out    (ampl_o)
    );

    lfsr_constants u_constants (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .degree_i (degree_o),
        .mask_o   (mask_o),
        .len_o    (len_o)
    );

    assign reset_o    = w_mode[0];
    assign transmit_o = w_mode[1];
    assign receive_o  = w_mode[2];
    assign loopback_o = w_mode[3];

endmodule

// File: tb/tb_lfsr_cfg_regs.sv
// tb/tb_lfsr_cfg_regs.sv - directed table-driven bench for lfsr_cfg_regs
module tb_lfsr_cfg_regs;

    logic        clk_i;
    logic        rst_ni;
    logic [6:0]  saddr_i;
    logic [31:0] sdata_i;
    logic        s_strobe_i;
    logic        reset_o, transmit_o, receive_o, loopback_o;
    logic [4:0]  degree_o;
    logic [13:0] ampl_o;
    logic [15:0] mask_o;
    logic [16:0] len_o;

    int errors = 0;
    int checks = 0;

    lfsr_cfg_regs dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .saddr_i    (saddr_i),
        .sdata_i    (sdata_i),
        .s_strobe_i (s_strobe_i),
        .reset_o    (reset_o),
        .transmit_o (transmit_o),
        .receive_o  (receive_o),
        .loopback_o (loopback_o),
        .degree_o   (degree_o),
        .ampl_o     (ampl_o),
        .mask_o     (mask_o),
        .len_o      (len_o)
    );

    initial clk_i = 1'b0;
    always #8 clk_i = ~clk_i;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [3:0]  mode;
        logic [4:0]  deg;
        logic [13:0] ampl;
        logic [15:0] mask;
        logic [16:0] len;
    } vec_t;

    vec_t vecs [10];

    logic [15:0] exp_mask_tbl [17] = '{
        16'h0000, 16'h0001, 16'h0003, 16'h0005, 16'h0009, 16'h0012,
        16'h0021, 16'h0041, 16'h008E, 16'h0108, 16'h0204, 16'h0402,
        16'h0829, 16'h100D, 16'h2015, 16'h4001, 16'h8016
    };

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] mode, input logic [4:0] deg,
                             input logic [13:0] ampl, input logic [15:0] mask, input logic [16:0] len);
        check({tag, ".mode"}, {28'd0, loopback_o, receive_o, transmit_o, reset_o}, {28'd0, mode});
        check({tag, ".degree"}, {27'd0, degree_o}, {27'd0, deg});
        check({tag, ".ampl"}, {18'd0, ampl_o}, {18'd0, ampl});
        check({tag, ".mask"}, {16'd0, mask_o}, {16'd0, mask});
        check({tag, ".len"}, {15'd0, len_o}, {15'd0, len});
    endtask

    // One strobe cycle, then one idle edge so mask/len have caught up.
    task automatic write_settle(input logic [6:0] addr, input logic [31:0] data);
        @(negedge clk_i);
        saddr_i    = addr;
        sdata_i    = data;
        s_strobe_i = 1'b1;
        @(negedge clk_i);
        s_strobe_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        logic [15:0] em;
        logic [16:0] el;

        vecs[0] = '{7'd64, 32'h0000000A, 4'hA, 5'd0,  14'h0000, 16'h0000, 17'd0};
        vecs[1] = '{7'd67, 32'h0000000F, 4'hA, 5'd0,  14'h0000, 16'h0000, 17'd0};
        vecs[2] = '{7'd66, 32'h00012345, 4'hA, 5'd0,  14'h2345, 16'h0000, 17'd0};
        vecs[3] = '{7'd65, 32'hFFFFFFE8, 4'hA, 5'd8,  14'h2345, 16'h008E, 17'd255};
        vecs[4] = '{7'd64, 32'hFFFFFFF5, 4'h5, 5'd8,  14'h2345, 16'h008E, 17'd255};
        vecs[5] = '{7'd65, 32'h00000010, 4'h5, 5'd16, 14'h2345, 16'h8016, 17'd65535};
        vecs[6] = '{7'd65, 32'h00000014, 4'h5, 5'd20, 14'h2345, 16'h0000, 17'd0};
        vecs[7] = '{7'd63, 32'hFFFFFFFF, 4'h5, 5'd20, 14'h2345, 16'h0000, 17'd0};
        vecs[8] = '{7'd66, 32'hFFFFC000, 4'h5, 5'd20, 14'h0000, 16'h0000, 17'd0};
        vecs[9] = '{7'd65, 32'h0000000D, 4'h5, 5'd13, 14'h0000, 16'h100D, 17'd8191};

        rst_ni     = 1'b0;
        saddr_i    = 7'd65;
        sdata_i    = 32'd16;
        s_strobe_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_all("reset_write_ignored", 4'h0, 5'd0, 14'h0, 16'h0, 17'd0);
        s_strobe_i = 1'b0;
        rst_ni     = 1'b1;
        @(negedge clk_i);
        check_all("after_release", 4'h0, 5'd0, 14'h0, 16'h0, 17'd0);

        // Degree latency: degree visible after edge N, mask/len after edge N+1.
        saddr_i    = 7'd65;
        sdata_i    = 32'hFFFFFFE8;
        s_strobe_i = 1'b1;
        @(negedge clk_i);
        s_strobe_i = 1'b0;
        check("lat.degree_N", {27'd0, degree_o}, 32'd8);
        check("lat.mask_N", {16'd0, mask_o}, 32'h0);
        check("lat.len_N", {15'd0, len_o}, 32'd0);
        @(negedge clk_i);
        check("lat.mask_N1", {16'd0, mask_o}, 32'h008E);
        check("lat.len_N1", {15'd0, len_o}, 32'd255);
        write_settle(7'd65, 32'd0);

        for (int i = 0; i < 10; i++) begin
            write_settle(vecs[i].addr, vecs[i].data);
            check_all($sformatf("vec%0d", i), vecs[i].mode, vecs[i].deg, vecs[i].ampl,
                      vecs[i].mask, vecs[i].len);
        end

        for (int d = 0; d < 32; d++) begin
            write_settle(7'd65, 32'hFFFF_FF00 | 32'(d));
            em = (d <= 16) ? exp_mask_tbl[d] : 16'h0;
            el = (d <= 16) ? 17'((32'd1 << d) - 32'd1) : 17'd0;
            check($sformatf("sweep%0d.degree", d), {27'd0, degree_o}, 32'(d));
            check($sformatf("sweep%0d.mask", d), {16'd0, mask_o}, {16'd0, em});
            check($sformatf("sweep%0d.len", d), {15'd0, len_o}, {15'd0, el});
        end

        @(negedge clk_i);
        saddr_i    = 7'd66;
        sdata_i    = 32'h1;
        s_strobe_i = 1'b1;
        @(negedge clk_i);
        check("b2b.first", {18'd0, ampl_o}, 32'h1);
        sdata_i = 32'h3FFF;
        @(negedge clk_i);
        s_strobe_i = 1'b0;
        check("b2b.last", {18'd0, ampl_o}, 32'h3FFF);

        write_settle(7'd64, 32'h3);
        write_settle(7'd65, 32'd10);
        check_all("pre_async", 4'h3, 5'd10, 14'h3FFF, 16'h0204, 17'd1023);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check_all("async_reset", 4'h0, 5'd0, 14'h0, 16'h0, 17'd0);
        @(negedge clk_i);
        rst_ni     = 1'b1;
        saddr_i    = 7'd66;
        sdata_i    = 32'h55;
        s_strobe_i = 1'b1;
        @(negedge clk_i);
        s_strobe_i = 1'b0;
        check("first_write_after_release", {18'd0, ampl_o}, 32'h55);
        check("degree_after_release", {27'd0, degree_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
